lpc_ring_writer: RTL and testbench
==================================

# lpc_ring_writer

Parametrised successor of the LPC frame-to-memory writer. Takes decoded LPC cycles from the sniffer front end and serialises each one into a fixed 8-byte slot of a ring buffer in byte-wide RAM. It manages the write pointer, slot occupancy, overflow marking and drop counting itself. It sits between the LPC decoder and the RAM/UART readout path; the readout side frees slots with a release strobe.

## Interface
Parameters:
- SLOT_BITS, 5: log2 of the slot count. DEPTH = 2**SLOT_BITS.
- ADDR_BYTES, 4: address bytes emitted per record (1..4). The low ADDR_BYTES*8 bits of lpc_addr are emitted, MSB first.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- lpc_cyctype_dir  in  4  cycle type + direction, LPC spec encoding.
- lpc_addr  in  32  cycle address (i/o uses low 16 bits).
- lpc_data  in  8  data byte.
- lpc_latch  in  1  one-cycle strobe; inputs valid in the same cycle.
- slot_release  in  1  one-cycle strobe; the consumer frees the oldest slot.
- ram_addr  out  SLOT_BITS+3  {slot index, byte index}.
- ram_data  out  8  byte to write.
- ram_we  out  1  write enable; the byte is written on the rising edge where ram_we=1.
- frame_done  out  1  one-cycle pulse coincident with the last byte of a record.
- wr_slot  out  SLOT_BITS  slot the next record will occupy.
- level  out  SLOT_BITS+1  committed, unreleased slots (0..DEPTH).
- drop_count  out  8  saturating count of discarded cycles.

## Operation
- Record layout, per slot:
  - byte 0 = {ovf, seq[2:0], cyctype_dir[3:0]}.
  - bytes 1..ADDR_BYTES = address, MSB first.
  - byte ADDR_BYTES+1 = data.
  - Remaining slot bytes are never written.
- Record length is L = ADDR_BYTES+2 bytes.
- Capture: a single pending register. lpc_latch with pending empty loads the pending register.
- lpc_latch with pending full drops the new cycle: drop_count++ and ovf_flag=1.
- FSM states:
  - IDLE: if pending is valid, evaluate the start of a record; otherwise stay.
  - Start of record:
    - If level == DEPTH, discard the pending entry, increment drop_count, set ovf_flag=1, remain IDLE.
    - Otherwise move pending into the working register, clear pending, go to HDR.
  - HDR: write byte 0 with ovf = ovf_flag, then clear ovf_flag → ADDR.
  - ADDR: write address bytes using a byte counter → DATA after ADDR_BYTES writes.
  - DATA: write the data byte and assert frame_done.
    - Then wr_slot++ (wraps modulo DEPTH), seq++ (wraps at 8), level++.
    - Next state: HDR directly if a pending entry is valid and level after increment < DEPTH. Otherwise IDLE, where the full check repeats.
- level arithmetic:
  - Increment at frame_done; decrement on slot_release.
  - Both in the same cycle: unchanged.
  - slot_release at level 0: ignored.
- drop_count saturates at 255 and is cleared only by reset.
- A latch in the same cycle the pending register is emptied, at record start, is accepted into pending.
- Reset mid-record: the in-flight record is abandoned. No frame_done, and partial slot contents are don't-care.

## Timing
- Reset values: ram_we=0, frame_done=0, ram_addr=0, ram_data=0, wr_slot=0, level=0, drop_count=0. Internally seq=0, ovf_flag=0, pending empty, state IDLE.
- Latch in cycle N with FSM idle and ring not full:
  - Pending is valid from N+1.
  - Start evaluated in N+1; first ram_we in N+2.
  - Last byte plus frame_done in N+1+L.
- Back-to-back records: no gap cycles between frame_done and the next HDR write. Sustained rate is one record per L cycles.
- ram_addr, ram_data and ram_we are registered outputs, stable for the whole write cycle.
- level and wr_slot update on the edge after frame_done.

## Structure
- Shared package lpc_pkg holds:
  - the cycle-type encodings;
  - the FSM state typedef (IDLE, HDR, ADDR, DATA);
  - the header field offsets;
  - SLOT_BYTES=8.
- One natural sub-module: lpc_slot_tracker. It holds wr_slot, level and the full flag, with inputs for commit/release.
- Elaboration-time check: ADDR_BYTES in 1..4, so that L ≤ 8.

## Test plan
- Single cycle: cyctype 0x4, addr 0x0000_0080, data 0x5A, ADDR_BYTES=4.
  - Slot 0 gets bytes 0x04, 0x00, 0x00, 0x00, 0x80, 0x5A at addresses 0..5.
  - frame_done is asserted on the 0x5A write.
  - level=1 and wr_slot=1 afterwards.
- Three latches on consecutive cycles:
  - The first two are written back-to-back with seq 0 and 1.
  - The third is dropped: drop_count=1.
  - The next record header has bit 7 set.
- Fill DEPTH=32 slots with no release, then latch once: no RAM write, drop_count=1, level=32. Then pulse slot_release: the pending-free cycle after release is written to slot 0 with ovf=1.
- slot_release concurrent with frame_done: level unchanged. slot_release at level 0: level stays 0.
- ADDR_BYTES=2, SLOT_BITS=3, i/o addr 0x002E, data 0x11:
  - Bytes written are hdr, 0x00, 0x2E, 0x11.
  - After 9 records, wr_slot wraps to 1 and seq reads 0 on record 9.
- Assert reset during the ADDR state: no frame_done, all outputs return to reset values the next cycle, and the next record lands in slot 0 with seq 0.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC ring writer: cycle-type codes, FSM states,
// record header field layout and slot geometry.
package lpc_pkg;

  localparam int SLOT_BYTES = 8;

  // cyctype_dir nibble: [3:2] cycle type, [1] direction (1 = write), [0] reserved
  localparam logic [3:0] CYC_IO_RD  = 4'h0;
  localparam logic [3:0] CYC_IO_WR  = 4'h2;
  localparam logic [3:0] CYC_MEM_RD = 4'h4;
  localparam logic [3:0] CYC_MEM_WR = 4'h6;
  localparam logic [3:0] CYC_DMA_RD = 4'h8;
  localparam logic [3:0] CYC_DMA_WR = 4'hA;

  localparam int HDR_OVF_BIT  = 7;
  localparam int HDR_SEQ_LSB  = 4;
  localparam int HDR_TYPE_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    ADDR,
    DATA
  } lpc_state_e;

  function automatic logic [7:0] make_hdr(input logic ovf, input logic [2:0] seq,
                                          input logic [3:0] cyc);
    logic [7:0] h;
    h = 8'h00;
    h[HDR_OVF_BIT]         = ovf;
    h[HDR_SEQ_LSB +: 3]    = seq;
    h[HDR_TYPE_LSB +: 4]   = cyc;
    return h;
  endfunction

endpackage

// File: rtl/lpc_slot_tracker.sv
// Ring occupancy bookkeeping: write slot, committed level and full flags.
// The *_next outputs let the writer look one edge ahead when chaining records.
module lpc_slot_tracker #(
  parameter int SLOT_BITS = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 commit,
  input  logic                 slot_release,
  output logic [SLOT_BITS-1:0] wr_slot,
  output logic [SLOT_BITS-1:0] wr_slot_next,
  output logic [SLOT_BITS:0]   level,
  output logic                 full,
  output logic                 full_next
);

  localparam logic [SLOT_BITS:0] DEPTH = {1'b1, {SLOT_BITS{1'b0}}};

  logic [SLOT_BITS-1:0] wr_slot_reg;
  logic [SLOT_BITS:0]   level_reg;
  logic [SLOT_BITS:0]   level_next;
  logic                 rel_eff;

  always_comb begin
    rel_eff      = slot_release && (level_reg != '0);
    wr_slot_next = wr_slot_reg + SLOT_BITS'(commit);
    level_next   = level_reg;
    if (commit && !rel_eff)
      level_next = level_reg + (SLOT_BITS+1)'(1);
    else if (!commit && rel_eff)
      level_next = level_reg - (SLOT_BITS+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_slot_reg <= '0;
      level_reg   <= '0;
    end else begin
      wr_slot_reg <= wr_slot_next;
      level_reg   <= level_next;
    end
  end

  assign wr_slot   = wr_slot_reg;
  assign level     = level_reg;
  assign full      = (level_reg == DEPTH);
  assign full_next = (level_next == DEPTH);

endmodule

// File: rtl/lpc_ring_writer.sv
// Serialises decoded LPC cycles into fixed 8-byte ring slots of a byte-wide RAM.
// RAM outputs are registered from the next-state decode, so each byte is stable for its whole write cycle.
module lpc_ring_writer
  import lpc_pkg::*;
#(
  parameter int SLOT_BITS  = 5,
  parameter int ADDR_BYTES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           lpc_cyctype_dir,
  input  logic [31:0]          lpc_addr,
  input  logic [7:0]           lpc_data,
  input  logic                 lpc_latch,
  input  logic                 slot_release,
  output logic [SLOT_BITS+2:0] ram_addr,
  output logic [7:0]           ram_data,
  output logic                 ram_we,
  output logic                 frame_done,
  output logic [SLOT_BITS-1:0] wr_slot,
  output logic [SLOT_BITS:0]   level,
  output logic [7:0]           drop_count
);

  localparam int IDX_BITS = $clog2(SLOT_BYTES);
  localparam int AW_BITS  = ADDR_BYTES * 8;
  localparam logic [IDX_BITS-1:0] LAST_ADDR_IDX = IDX_BITS'(ADDR_BYTES);
  localparam logic [IDX_BITS-1:0] DATA_IDX      = IDX_BITS'(ADDR_BYTES + 1);

  if (ADDR_BYTES < 1 || ADDR_BYTES > 4) begin : g_bad_addr_bytes
    $error("lpc_ring_writer: ADDR_BYTES must be in 1..4");
  end

  lpc_state_e state_reg, state_next;

  logic                 pend_valid_reg;
  logic [3:0]           pend_cyc_reg;
  logic [AW_BITS-1:0]   pend_addr_reg;
  logic [7:0]           pend_data_reg;
  logic [AW_BITS-1:0]   work_addr_reg;
  logic [7:0]           work_data_reg;
  logic [IDX_BITS-1:0]  byte_idx_reg;
  logic [2:0]           seq_reg, seq_next;
  logic                 ovf_flag_reg;
  logic [7:0]           drop_count_reg;
  logic [SLOT_BITS+2:0] ram_addr_reg;
  logic [7:0]           ram_data_reg;
  logic                 ram_we_reg;
  logic                 frame_done_reg;

  logic                 take, discard, lat_drop, drop_inc, pend_load;
  logic                 emit_we, emit_done;
  logic [IDX_BITS-1:0]  emit_idx, next_idx;
  logic [7:0]           emit_byte, hdr_byte;
  logic [SLOT_BITS-1:0] wr_slot_next;
  logic                 full, full_next;
  logic [7:0]           addr_byte [SLOT_BYTES];
  logic                 lpc_addr_unused;

  assign lpc_addr_unused = ^lpc_addr;

  // Byte lane k (1..ADDR_BYTES) of the record carries address byte ADDR_BYTES-k, MSB first.
  for (genvar gi = 0; gi < SLOT_BYTES; gi++) begin : g_addr_byte
    if (gi >= 1 && gi <= ADDR_BYTES) begin : g_on
      assign addr_byte[gi] = work_addr_reg[(ADDR_BYTES-gi)*8 +: 8];
    end else begin : g_off
      assign addr_byte[gi] = 8'h00;
    end
  end

  lpc_slot_tracker #(.SLOT_BITS(SLOT_BITS)) u_tracker (
    .clock        (clock),
    .reset        (reset),
    .commit       (frame_done_reg),
    .slot_release (slot_release),
    .wr_slot      (wr_slot),
    .wr_slot_next (wr_slot_next),
    .level        (level),
    .full         (full),
    .full_next    (full_next)
  );

  assign seq_next = seq_reg + {2'b00, frame_done_reg};
  assign next_idx = byte_idx_reg + IDX_BITS'(1);
  assign hdr_byte = make_hdr(ovf_flag_reg, seq_next, pend_cyc_reg);

  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    discard    = 1'b0;
    emit_we    = 1'b0;
    emit_done  = 1'b0;
    emit_idx   = byte_idx_reg;
    emit_byte  = 8'h00;
    case (state_reg)
      IDLE: begin
        if (pend_valid_reg) begin
          if (full) begin
            discard = 1'b1;
          end else begin
            take       = 1'b1;
            state_next = HDR;
            emit_we    = 1'b1;
            emit_idx   = '0;
            emit_byte  = hdr_byte;
          end
        end
      end
      HDR: begin
        state_next = ADDR;
        emit_we    = 1'b1;
        emit_idx   = next_idx;
        emit_byte  = addr_byte[next_idx];
      end
      ADDR: begin
        emit_we = 1'b1;
        if (byte_idx_reg == LAST_ADDR_IDX) begin
          state_next = DATA;
          emit_done  = 1'b1;
          emit_idx   = DATA_IDX;
          emit_byte  = work_data_reg;
        end else begin
          emit_idx  = next_idx;
          emit_byte = addr_byte[next_idx];
        end
      end
      DATA: begin
        // Chain straight into the next header when the ring still has room after this commit.
        if (pend_valid_reg && !full_next) begin
          take       = 1'b1;
          state_next = HDR;
          emit_we    = 1'b1;
          emit_idx   = '0;
          emit_byte  = hdr_byte;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign lat_drop  = lpc_latch && pend_valid_reg && !take && !discard;
  assign drop_inc  = discard || lat_drop;
  assign pend_load = lpc_latch && !lat_drop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      pend_valid_reg <= 1'b0;
      byte_idx_reg   <= '0;
      seq_reg        <= '0;
      ovf_flag_reg   <= 1'b0;
      drop_count_reg <= '0;
      ram_addr_reg   <= '0;
      ram_data_reg   <= '0;
      ram_we_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pend_valid_reg <= pend_load || (pend_valid_reg && !take && !discard);
      seq_reg        <= seq_next;
      ram_we_reg     <= emit_we;
      frame_done_reg <= emit_done;
      if (emit_we) begin
        ram_addr_reg <= {wr_slot_next, emit_idx};
        ram_data_reg <= emit_byte;
        byte_idx_reg <= emit_idx;
      end
      if (drop_inc)
        ovf_flag_reg <= 1'b1;
      else if (take)
        ovf_flag_reg <= 1'b0;
      if (drop_inc && drop_count_reg != 8'hFF)
        drop_count_reg <= drop_count_reg + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (pend_load) begin
      pend_cyc_reg  <= lpc_cyctype_dir;
      pend_addr_reg <= lpc_addr[AW_BITS-1:0];
      pend_data_reg <= lpc_data;
    end
    if (take) begin
      work_addr_reg <= pend_addr_reg;
      work_data_reg <= pend_data_reg;
    end
  end

  assign ram_addr   = ram_addr_reg;
  assign ram_data   = ram_data_reg;
  assign ram_we     = ram_we_reg;
  assign frame_done = frame_done_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_lpc_ring_writer.sv
// Directed bench for lpc_ring_writer: default instance (32 slots, 4 address bytes)
// and a small instance (8 slots, 2 address bytes) for the i/o and wrap cases.
module tb_lpc_ring_writer;
  import lpc_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        a_rst, a_latch, a_rel;
  logic [3:0]  a_cyc;
  logic [31:0] a_addr;
  logic [7:0]  a_data;
  logic [7:0]  a_ram_addr;
  logic [7:0]  a_ram_data;
  logic        a_ram_we, a_frame_done;
  logic [4:0]  a_wr_slot;
  logic [5:0]  a_level;
  logic [7:0]  a_drop;

  logic        b_rst, b_latch, b_rel;
  logic [3:0]  b_cyc;
  logic [31:0] b_addr;
  logic [7:0]  b_data;
  logic [5:0]  b_ram_addr;
  logic [7:0]  b_ram_data;
  logic        b_ram_we, b_frame_done;
  logic [2:0]  b_wr_slot;
  logic [3:0]  b_level;
  logic [7:0]  b_drop;

  int errors = 0;
  int checks = 0;
  int we_cnt_a = 0;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [64];

  lpc_ring_writer dut_a (
    .clock(clock), .reset(a_rst), .lpc_cyctype_dir(a_cyc), .lpc_addr(a_addr),
    .lpc_data(a_data), .lpc_latch(a_latch), .slot_release(a_rel),
    .ram_addr(a_ram_addr), .ram_data(a_ram_data), .ram_we(a_ram_we),
    .frame_done(a_frame_done), .wr_slot(a_wr_slot), .level(a_level), .drop_count(a_drop)
  );

  lpc_ring_writer #(.SLOT_BITS(3), .ADDR_BYTES(2)) dut_b (
    .clock(clock), .reset(b_rst), .lpc_cyctype_dir(b_cyc), .lpc_addr(b_addr),
    .lpc_data(b_data), .lpc_latch(b_latch), .slot_release(b_rel),
    .ram_addr(b_ram_addr), .ram_data(b_ram_data), .ram_we(b_ram_we),
    .frame_done(b_frame_done), .wr_slot(b_wr_slot), .level(b_level), .drop_count(b_drop)
  );

  // RAM model: capture every write away from the active edge
  always @(negedge clock) begin
    if (a_ram_we === 1'b1) begin
      mem_a[a_ram_addr] = a_ram_data;
      we_cnt_a++;
    end
    if (b_ram_we === 1'b1)
      mem_b[b_ram_addr] = b_ram_data;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic latch_a(input logic [3:0] c, input logic [31:0] ad, input logic [7:0] d);
    a_cyc = c; a_addr = ad; a_data = d; a_latch = 1'b1;
    tick();
    a_latch = 1'b0;
  endtask

  task automatic latch_b(input logic [3:0] c, input logic [31:0] ad, input logic [7:0] d);
    b_cyc = c; b_addr = ad; b_data = d; b_latch = 1'b1;
    tick();
    b_latch = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n;
    n = 0;
    while (a_frame_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(a_frame_done), 32'd1);
  endtask

  task automatic wait_done_b(input string tag);
    int n;
    n = 0;
    while (b_frame_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(b_frame_done), 32'd1);
  endtask

  task automatic reset_a();
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
  endtask

  task automatic pulse_rel_a();
    a_rel = 1'b1;
    tick();
    a_rel = 1'b0;
  endtask

  task automatic pulse_rel_b();
    b_rel = 1'b1;
    tick();
    b_rel = 1'b0;
  endtask

  initial begin
    int base;
    int dones;
    for (int i = 0; i < 256; i++) mem_a[i] = 8'hEE;
    for (int i = 0; i < 64; i++)  mem_b[i] = 8'hEE;
    a_rst = 1'b1; a_latch = 1'b0; a_rel = 1'b0; a_cyc = '0; a_addr = '0; a_data = '0;
    b_rst = 1'b1; b_latch = 1'b0; b_rel = 1'b0; b_cyc = '0; b_addr = '0; b_data = '0;
    repeat (3) tick();
    a_rst = 1'b0;
    b_rst = 1'b0;

    chk("rst_ram_we",     32'(a_ram_we),     32'd0);
    chk("rst_frame_done", 32'(a_frame_done), 32'd0);
    chk("rst_ram_addr",   32'(a_ram_addr),   32'd0);
    chk("rst_ram_data",   32'(a_ram_data),   32'd0);
    chk("rst_wr_slot",    32'(a_wr_slot),    32'd0);
    chk("rst_level",      32'(a_level),      32'd0);
    chk("rst_drop",       32'(a_drop),       32'd0);

    // Single memory-read record, exact latency
    latch_a(CYC_MEM_RD, 32'h0000_0080, 8'h5A);
    chk("t1_pending_no_we", 32'(a_ram_we), 32'd0);
    tick();
    chk("t1_hdr_we",   32'(a_ram_we),   32'd1);
    chk("t1_hdr_addr", 32'(a_ram_addr), 32'd0);
    chk("t1_hdr_data", 32'(a_ram_data), 32'h04);
    repeat (4) tick();
    chk("t1_a0_addr", 32'(a_ram_addr),   32'd4);
    chk("t1_a0_data", 32'(a_ram_data),   32'h80);
    chk("t1_a0_done", 32'(a_frame_done), 32'd0);
    tick();
    chk("t1_data_addr", 32'(a_ram_addr),   32'd5);
    chk("t1_data_data", 32'(a_ram_data),   32'h5A);
    chk("t1_data_done", 32'(a_frame_done), 32'd1);
    tick();
    chk("t1_level",   32'(a_level),      32'd1);
    chk("t1_wr_slot", 32'(a_wr_slot),    32'd1);
    chk("t1_done_lo", 32'(a_frame_done), 32'd0);
    chk("t1_we_lo",   32'(a_ram_we),     32'd0);
    for (int i = 1; i < 4; i++) chk("t1_mem_addr_hi", 32'(mem_a[i]), 32'h00);
    chk("t1_unwritten", 32'(mem_a[6]), 32'hEE);

    // Three latches on consecutive cycles: two records back-to-back, third dropped
    reset_a();
    a_cyc = CYC_MEM_WR; a_addr = 32'h60;   a_data = 8'h11; a_latch = 1'b1; tick();
    a_cyc = CYC_IO_WR;  a_addr = 32'h64;   a_data = 8'h22; tick();
    a_cyc = CYC_DMA_WR; a_addr = 32'h1000; a_data = 8'h33; tick();
    a_latch = 1'b0;
    chk("t2_drop", 32'(a_drop), 32'd1);
    wait_done_a("t2_done0");
    chk("t2_r0_data", 32'(a_ram_data), 32'h11);
    chk("t2_r0_addr", 32'(a_ram_addr), 32'd5);
    tick();
    chk("t2_b2b_we",   32'(a_ram_we),   32'd1);
    chk("t2_b2b_addr", 32'(a_ram_addr), 32'd8);
    chk("t2_b2b_hdr",  32'(a_ram_data), 32'h92);
    wait_done_a("t2_done1");
    chk("t2_r1_data", 32'(a_ram_data), 32'h22);
    chk("t2_r1_addr", 32'(a_ram_addr), 32'd13);
    tick();
    chk("t2_level",   32'(a_level),   32'd2);
    chk("t2_drop_hold", 32'(a_drop),  32'd1);
    chk("t2_r0_hdr",  32'(mem_a[0]),  32'h06);
    chk("t2_r1_addr0", 32'(mem_a[12]), 32'h64);

    // Fill the ring, then latch into a full ring
    reset_a();
    for (int i = 0; i < 32; i++) begin
      latch_a(CYC_IO_WR, 32'(i), 8'(i));
      wait_done_a("t3_fill_done");
      tick();
    end
    chk("t3_full_level",   32'(a_level),   32'd32);
    chk("t3_full_wr_slot", 32'(a_wr_slot), 32'd0);
    base = we_cnt_a;
    latch_a(CYC_MEM_WR, 32'hAB, 8'h77);
    repeat (4) tick();
    chk("t3_no_write",   32'(we_cnt_a - base), 32'd0);
    chk("t3_drop",       32'(a_drop),          32'd1);
    chk("t3_level_hold", 32'(a_level),         32'd32);
    pulse_rel_a();
    chk("t3_rel_level", 32'(a_level), 32'd31);
    latch_a(CYC_IO_WR, 32'h3F8, 8'h99);
    wait_done_a("t3_after_rel_done");
    chk("t3_after_rel_addr", 32'(a_ram_addr), 32'd5);
    tick();
    chk("t3_ovf_hdr",  32'(mem_a[0]),  32'h82);
    chk("t3_addr_lsb", 32'(mem_a[4]),  32'hF8);
    chk("t3_data",     32'(mem_a[5]),  32'h99);
    chk("t3_level",    32'(a_level),   32'd32);
    chk("t3_wr_slot",  32'(a_wr_slot), 32'd1);

    // Release coincident with frame_done, and release at level 0
    pulse_rel_a();
    latch_a(CYC_MEM_RD, 32'h44, 8'h55);
    wait_done_a("t4_done");
    a_rel = 1'b1;
    tick();
    a_rel = 1'b0;
    chk("t4_concurrent_level", 32'(a_level), 32'd31);
    reset_a();
    chk("t4_reset_level", 32'(a_level), 32'd0);
    pulse_rel_a();
    chk("t4_rel_at_zero", 32'(a_level), 32'd0);

    // Small instance: 2 address bytes, 8 slots
    latch_b(CYC_IO_RD, 32'h0000_002E, 8'h11);
    tick();
    chk("t5_hdr_we",   32'(b_ram_we),   32'd1);
    chk("t5_hdr_addr", 32'(b_ram_addr), 32'd0);
    chk("t5_hdr_data", 32'(b_ram_data), 32'h00);
    tick();
    chk("t5_a1_addr", 32'(b_ram_addr), 32'd1);
    chk("t5_a1_data", 32'(b_ram_data), 32'h00);
    tick();
    chk("t5_a0_addr", 32'(b_ram_addr), 32'd2);
    chk("t5_a0_data", 32'(b_ram_data), 32'h2E);
    tick();
    chk("t5_d_addr", 32'(b_ram_addr),   32'd3);
    chk("t5_d_data", 32'(b_ram_data),   32'h11);
    chk("t5_d_done", 32'(b_frame_done), 32'd1);
    tick();
    chk("t5_level",   32'(b_level),   32'd1);
    chk("t5_wr_slot", 32'(b_wr_slot), 32'd1);
    pulse_rel_b();
    for (int k = 1; k <= 8; k++) begin
      latch_b(CYC_IO_WR, 32'h60 + 32'(k), 8'(k));
      wait_done_b("t5_loop_done");
      tick();
      pulse_rel_b();
    end
    chk("t5_wrap_wr_slot", 32'(b_wr_slot), 32'd1);
    chk("t5_wrap_level",   32'(b_level),   32'd0);
    chk("t5_r9_hdr",       32'(mem_b[0]),  32'h02);
    chk("t5_r9_addr",      32'(mem_b[2]),  32'h68);
    chk("t5_r9_data",      32'(mem_b[3]),  32'h08);
    chk("t5_r1_hdr",       32'(mem_b[8]),  32'h12);
    chk("t5_drop",         32'(b_drop),    32'd0);

    // Reset while a record is in its address phase
    reset_a();
    latch_a(CYC_MEM_RD, 32'h10, 8'h01);
    wait_done_a("t6_first_done");
    tick();
    latch_a(CYC_MEM_WR, 32'h20, 8'h02);
    tick();
    tick();
    chk("t6_in_addr_we",   32'(a_ram_we),   32'd1);
    chk("t6_in_addr_addr", 32'(a_ram_addr), 32'd9);
    a_rst = 1'b1;
    tick();
    chk("t6_rst_we",      32'(a_ram_we),     32'd0);
    chk("t6_rst_done",    32'(a_frame_done), 32'd0);
    chk("t6_rst_addr",    32'(a_ram_addr),   32'd0);
    chk("t6_rst_data",    32'(a_ram_data),   32'd0);
    chk("t6_rst_wr_slot", 32'(a_wr_slot),    32'd0);
    chk("t6_rst_level",   32'(a_level),      32'd0);
    chk("t6_rst_drop",    32'(a_drop),       32'd0);
    a_rst = 1'b0;
    dones = 0;
    repeat (8) begin
      tick();
      if (a_frame_done === 1'b1) dones++;
    end
    chk("t6_no_done", 32'(dones), 32'd0);
    latch_a(CYC_MEM_WR, 32'h1234, 8'h42);
    wait_done_a("t6_next_done");
    chk("t6_next_addr", 32'(a_ram_addr), 32'd5);
    tick();
    chk("t6_next_hdr",   32'(mem_a[0]), 32'h06);
    chk("t6_next_a1",    32'(mem_a[3]), 32'h12);
    chk("t6_next_level", 32'(a_level),  32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
